// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - Mini-SRC control strobe bundle between control_unit and datapath
interface control_unit_if;
  logic [31:0] IR;
  logic        mem_ready;
  logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin;
  logic        IncPC, Read;
  logic [4:0]  opcode;
  logic        run;
  logic        illegal;

  modport master (
    input  IR, mem_ready,
    output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Rout, Rin,
           MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin,
           IncPC, Read, opcode, run, illegal
  );

  modport slave (
    output IR, mem_ready,
    input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Rout, Rin,
           MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin,
           IncPC, Read, opcode, run, illegal
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired T-state sequencer for the Mini-SRC datapath
module control_unit (
  input logic           clock,
  input logic           clear,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t      state;
  logic        t1_first;
  logic        illegal_q;

  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic        is_alu3, is_unary, is_muldiv, is_mfhi, is_mflo, is_nop, is_halt, is_legal;

  assign op = bus.IR[31:27];
  assign ra = bus.IR[26:23];
  assign rb = bus.IR[22:19];
  assign rc = bus.IR[18:15];

  assign is_alu3   = (op >= 5'b00011) && (op <= 5'b01011);
  assign is_unary  = (op == 5'b10001) || (op == 5'b10010);
  assign is_muldiv = (op == 5'b01111) || (op == 5'b10000);
  assign is_mfhi   = (op == 5'b11000);
  assign is_mflo   = (op == 5'b11001);
  assign is_nop    = (op == 5'b11010);
  assign is_halt   = (op == 5'b11011);
  assign is_legal  = is_alu3 | is_unary | is_muldiv | is_mfhi | is_mflo | is_nop | is_halt;

  function automatic logic [15:0] onehot(input logic [3:0] f);
    return 16'h0001 << f;
  endfunction

  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= RST;
      t1_first  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        RST: state <= T0;
        T0: begin
          state    <= T1;
          t1_first <= 1'b1;
        end
        T1: begin
          t1_first <= 1'b0;
          if (bus.mem_ready) state <= T2;
        end
        T2: state <= T3;
        T3: begin
          // unsupported opcodes fall through as a nop but leave a sticky mark
          if (!is_legal) illegal_q <= 1'b1;
          if (is_alu3 || is_unary || is_muldiv) state <= T4;
          else if (is_halt)                     state <= HALT;
          else                                  state <= T0;
        end
        T4: state <= T5;
        T5: state <= is_muldiv ? T6 : T0;
        T6: state <= T0;
        HALT: state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.HIout    = 1'b0;
    bus.LOout    = 1'b0;
    bus.Rout     = 16'h0000;
    bus.Rin      = 16'h0000;
    bus.MARin    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.Zhighin  = 1'b0;
    bus.Zlowin   = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.opcode   = 5'b00000;
    bus.run      = (state != RST) && (state != HALT);
    bus.illegal  = illegal_q;

    case (state)
      T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      T1: begin
        // PC reload only once per fetch, however long the memory stalls
        bus.Zlowout = 1'b1;
        bus.PCin    = t1_first;
        bus.Read    = 1'b1;
        bus.MDRin   = bus.mem_ready;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        if (is_alu3) begin
          bus.Rout = onehot(rb);
          bus.Yin  = 1'b1;
        end else if (is_muldiv) begin
          bus.Rout = onehot(ra);
          bus.Yin  = 1'b1;
        end else if (is_mfhi) begin
          bus.HIout = 1'b1;
          bus.Rin   = onehot(ra);
        end else if (is_mflo) begin
          bus.LOout = 1'b1;
          bus.Rin   = onehot(ra);
        end
      end
      T4: begin
        bus.opcode = op;
        bus.Zlowin = 1'b1;
        if (is_alu3) begin
          bus.Rout = onehot(rc);
        end else begin
          bus.Rout    = onehot(rb);
          bus.Zhighin = is_muldiv;
        end
      end
      T5: begin
        bus.Zlowout = 1'b1;
        if (is_muldiv) bus.LOin = 1'b1;
        else           bus.Rin  = onehot(ra);
      end
      T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit
module tb_control_unit;

  logic clock = 1'b0;
  logic clear = 1'b0;

  control_unit_if cu_bus ();

  control_unit dut (
    .clock (clock),
    .clear (clear),
    .bus   (cu_bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin;
    logic        IncPC, Read;
    logic [4:0]  opcode;
    logic        run;
    logic        illegal;
  } strobe_t;

  strobe_t exp_q[$];
  int      n_chk = 0;
  int      n_err = 0;
  logic    exp_ill = 1'b0;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0000};
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] f);
    logic [15:0] one;
    one = 16'h0001;
    return one << f;
  endfunction

  function automatic strobe_t base();
    strobe_t s;
    s = '0;
    s.run = 1'b1;
    s.illegal = exp_ill;
    return s;
  endfunction

  function automatic strobe_t observe();
    strobe_t s;
    s.PCout = cu_bus.PCout;     s.MDRout = cu_bus.MDRout;   s.Zhighout = cu_bus.Zhighout;
    s.Zlowout = cu_bus.Zlowout; s.HIout = cu_bus.HIout;     s.LOout = cu_bus.LOout;
    s.Rout = cu_bus.Rout;       s.Rin = cu_bus.Rin;
    s.MARin = cu_bus.MARin;     s.PCin = cu_bus.PCin;       s.MDRin = cu_bus.MDRin;
    s.IRin = cu_bus.IRin;       s.Yin = cu_bus.Yin;         s.HIin = cu_bus.HIin;
    s.LOin = cu_bus.LOin;       s.Zhighin = cu_bus.Zhighin; s.Zlowin = cu_bus.Zlowin;
    s.IncPC = cu_bus.IncPC;     s.Read = cu_bus.Read;       s.opcode = cu_bus.opcode;
    s.run = cu_bus.run;         s.illegal = cu_bus.illegal;
    return s;
  endfunction

  task automatic tick_check(input string tag);
    strobe_t e, o;
    @(negedge clock);
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: got output with empty scoreboard, want queued entry", tag);
    end else begin
      e = exp_q.pop_front();
      o = observe();
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s: got %h want %h", tag, o, e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic push_fetch(input int stall);
    strobe_t s;
    s = base(); s.PCout = 1; s.MARin = 1; s.IncPC = 1; s.Zlowin = 1;
    exp_q.push_back(s);
    for (int k = 0; k <= stall; k++) begin
      s = base(); s.Zlowout = 1; s.Read = 1;
      s.PCin  = (k == 0);
      s.MDRin = (k == stall);
      exp_q.push_back(s);
    end
    s = base(); s.MDRout = 1; s.IRin = 1;
    exp_q.push_back(s);
  endtask

  task automatic push_exec(input logic [31:0] ir);
    strobe_t s;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    if (op >= 5'd3 && op <= 5'd11) begin
      s = base(); s.Rout = oh(rb); s.Yin = 1; exp_q.push_back(s);
      s = base(); s.Rout = oh(rc); s.opcode = op; s.Zlowin = 1; exp_q.push_back(s);
      s = base(); s.Zlowout = 1; s.Rin = oh(ra); exp_q.push_back(s);
    end else if (op == 5'b10001 || op == 5'b10010) begin
      s = base(); exp_q.push_back(s);
      s = base(); s.Rout = oh(rb); s.opcode = op; s.Zlowin = 1; exp_q.push_back(s);
      s = base(); s.Zlowout = 1; s.Rin = oh(ra); exp_q.push_back(s);
    end else if (op == 5'b01111 || op == 5'b10000) begin
      s = base(); s.Rout = oh(ra); s.Yin = 1; exp_q.push_back(s);
      s = base(); s.Rout = oh(rb); s.opcode = op; s.Zlowin = 1; s.Zhighin = 1; exp_q.push_back(s);
      s = base(); s.Zlowout = 1; s.LOin = 1; exp_q.push_back(s);
      s = base(); s.Zhighout = 1; s.HIin = 1; exp_q.push_back(s);
    end else if (op == 5'b11000) begin
      s = base(); s.HIout = 1; s.Rin = oh(ra); exp_q.push_back(s);
    end else if (op == 5'b11001) begin
      s = base(); s.LOout = 1; s.Rin = oh(ra); exp_q.push_back(s);
    end else if (op == 5'b11010) begin
      s = base(); exp_q.push_back(s);
    end else if (op == 5'b11011) begin
      s = base(); exp_q.push_back(s);
      for (int k = 0; k < 10; k++) begin
        s = '0; s.illegal = exp_ill; exp_q.push_back(s);
      end
    end else begin
      s = base(); exp_q.push_back(s);
      exp_ill = 1'b1;
    end
  endtask

  task automatic run_instr(input string name, input logic [31:0] ir, input int stall,
                           input int limit);
    int n;
    push_fetch(stall);
    push_exec(ir);
    n = exp_q.size();
    if (limit > 0 && limit < n) n = limit;
    for (int c = 0; c < n; c++) begin
      cu_bus.IR = (c < 3 + stall) ? $urandom : ir;
      if (c >= 1 && c <= 1 + stall) cu_bus.mem_ready = (c == 1 + stall);
      else                          cu_bus.mem_ready = 1'($urandom_range(0, 1));
      tick_check($sformatf("%s c%0d", name, c));
    end
    if (limit > 0) exp_q.delete();
  endtask

  task automatic do_reset(input string name);
    clear = 1'b0;
    cu_bus.IR = $urandom;
    cu_bus.mem_ready = 1'b1;
    exp_q.delete();
    exp_ill = 1'b0;
    @(posedge clock);
    #1;
    exp_q.push_back('0);
    tick_check({name, " rst0"});
    clear = 1'b1;
    exp_q.push_back('0);
    tick_check({name, " rst1"});
  endtask

  initial begin
    cu_bus.IR = '0;
    cu_bus.mem_ready = 1'b0;

    do_reset("init");
    run_instr("add", mk_ir(5'b00011, 4'd3, 4'd1, 4'd2), 0, 0);
    run_instr("sub_stall", mk_ir(5'b00100, 4'd5, 4'd6, 4'd7), 3, 0);
    run_instr("mul", mk_ir(5'b01111, 4'd4, 4'd5, 4'd0), 0, 0);
    run_instr("div", mk_ir(5'b10000, 4'd14, 4'd1, 4'd0), 1, 0);
    run_instr("neg", mk_ir(5'b10001, 4'd8, 4'd9, 4'd0), 0, 0);
    run_instr("not", mk_ir(5'b10010, 4'd0, 4'd15, 4'd0), 0, 0);
    run_instr("rol_r15", mk_ir(5'b01011, 4'd15, 4'd15, 4'd15), 0, 0);
    run_instr("and_r0", mk_ir(5'b00101, 4'd0, 4'd0, 4'd0), 0, 0);
    run_instr("mfhi", mk_ir(5'b11000, 4'd10, 4'd0, 4'd0), 0, 0);
    run_instr("mflo", mk_ir(5'b11001, 4'd0, 4'd0, 4'd0), 2, 0);
    run_instr("nop", mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), 0, 0);

    run_instr("add_part", mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 0, 5);
    do_reset("mid");
    run_instr("stall_part", mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 0, 2);
    do_reset("t1wait");

    run_instr("illegal", mk_ir(5'b11111, 4'd2, 4'd3, 4'd4), 0, 0);
    run_instr("add_after_ill", mk_ir(5'b00011, 4'd3, 4'd1, 4'd2), 0, 0);
    run_instr("mul_after_ill", mk_ir(5'b01111, 4'd6, 4'd7, 4'd0), 0, 0);
    do_reset("ill_clr");
    run_instr("add_post", mk_ir(5'b00011, 4'd3, 4'd1, 4'd2), 0, 0);

    run_instr("halt", mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, 0);
    do_reset("halt_exit");
    run_instr("nop_post", mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
